// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/acknowledge handshake.
// One request in flight at a time; the result is signalled by a one-cycle Mem_ack.
module mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 512
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        Read,
    input  logic        Write,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        Mem_ack,
    output logic        busy,
    output logic        err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);
    localparam bit         DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t         state_q;
    logic [2:0]     cnt_q;
    logic           run_q;
    logic           op_wr_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic           ack_q;
    logic           busy_q;
    logic           err_q;
    logic [31:0]    mem [DEPTH];

    logic           accept_d;
    logic           both_d;
    logic           go_ack_d;
    logic           cur_wr_d;
    logic [AW-1:0]  cur_idx_d;
    logic [31:0]    cur_wdata_d;

    function automatic logic [AW-1:0] wrap_idx(input logic [8:0] a);
        return AW'({23'd0, a} % $unsigned(DEPTH));
    endfunction

    // run_q keeps the first edge after clr release from accepting, which also
    // guarantees no array write can happen on an edge where clr is still high.
    assign both_d   = run_q && (state_q == IDLE) && Read && Write;
    assign accept_d = run_q && (state_q == IDLE) && (Read ^ Write);
    assign go_ack_d = (DIRECT && accept_d) || ((state_q == WAIT) && (cnt_q == 3'd1));

    // With LATENCY=1 the accept edge is also the ACK-entry edge, so use live inputs.
    assign cur_wr_d    = (state_q == IDLE) ? Write           : op_wr_q;
    assign cur_idx_d   = (state_q == IDLE) ? wrap_idx(addr)  : idx_q;
    assign cur_wdata_d = (state_q == IDLE) ? wdata           : wdata_q;

    always_ff @(posedge clk) begin
        if (accept_d) begin
            op_wr_q <= Write;
            idx_q   <= wrap_idx(addr);
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (go_ack_d && cur_wr_d) begin
            mem[cur_idx_d] <= cur_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            run_q   <= 1'b0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            ack_q <= go_ack_d;
            err_q <= both_d;
            if (go_ack_d && !cur_wr_d) begin
                rdata_q <= mem[cur_idx_d];
            end
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= DIRECT ? ACK : WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign Mem_ack = ack_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 1, 2 and 7: drivers push the
// expected acknowledge cycle and data, per-instance monitors pop and compare.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done [3];

    typedef struct {
        int          cyc;
        bit          is_rd;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    function automatic void check(input string name, input int lat,
                                  input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s (LATENCY=%0d) at cycle %0d: got %h expected %h",
                     name, lat, cyc, act, want);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 7;

        logic        clr, rd, wr, ack, busy, err;
        logic [8:0]  addr;
        logic [31:0] wdata, rdata;

        mem_responder #(.LATENCY(L)) dut (
            .clk(clk), .clr(clr), .Read(rd), .Write(wr), .addr(addr),
            .wdata(wdata), .rdata(rdata), .Mem_ack(ack), .busy(busy), .err(err)
        );

        exp_t        q[$];
        logic [31:0] mdl   [512];
        bit          known [512];
        logic [31:0] last_rd;
        bit          last_known;
        int          bs = -1, be = -2, err_cyc = -1;

        // Monitor: every acknowledge must match the oldest outstanding request.
        always @(negedge clk) begin
            exp_t e;
            if (ack) begin
                if (q.size() == 0) begin
                    check("spurious_ack", L, 32'(ack), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("ack_cycle", L, cyc, e.cyc);
                    if (e.chk) check(e.is_rd ? "read_data" : "rdata_hold", L, rdata, e.data);
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missing_ack", L, 32'(ack), 32'd1);
            end
            if (err || cyc == err_cyc) check("err_pulse", L, 32'(err), 32'(cyc == err_cyc));
            if (!clr) check("busy", L, 32'(busy), 32'(cyc >= bs && cyc <= be));
        end

        task automatic do_req(input bit r, input bit w, input logic [8:0] a, input logic [31:0] d);
            int   k;
            exp_t e;
            @(negedge clk);
            rd = r; wr = w; addr = a; wdata = d;
            @(posedge clk); #1;
            k = cyc;
            rd = 1'b0; wr = 1'b0; addr = a ^ 9'd1; wdata = ~d;
            if (r && w) begin
                err_cyc = k;
            end else begin
                bs = k; be = k + L - 1;
                e.cyc = k + L - 1; e.is_rd = r;
                if (r) begin
                    e.chk = known[a]; e.data = mdl[a];
                    last_rd = mdl[a]; last_known = known[a];
                end else begin
                    e.chk = last_known; e.data = last_rd;
                    mdl[a] = d; known[a] = 1'b1;
                end
                q.push_back(e);
                repeat (L) @(posedge clk);
            end
        endtask

        task automatic held_read(input logic [8:0] a);
            int   k;
            exp_t e;
            @(negedge clk);
            rd = 1'b1; wr = 1'b0; addr = a;
            @(posedge clk); #1;
            k = cyc;
            bs = k; be = k + L - 1;
            e.cyc = k + L - 1; e.is_rd = 1'b1; e.chk = known[a]; e.data = mdl[a];
            q.push_back(e);
            repeat (L + 1) @(posedge clk); #1;
            rd = 1'b0;
            bs = k + L + 1; be = k + 2 * L;
            e.cyc = k + 2 * L;
            q.push_back(e);
            last_rd = mdl[a]; last_known = known[a];
            repeat (L) @(posedge clk);
        endtask

        task automatic abort_write(input logic [8:0] a, input logic [31:0] d);
            @(negedge clk);
            wr = 1'b1; addr = a; wdata = d;
            @(posedge clk); #1;
            wr = 1'b0;
            be = cyc - 1;
            // With LATENCY=1 the write already committed on the accept edge.
            if (L == 1) begin mdl[a] = d; known[a] = 1'b1; end
            clr = 1'b1;
            #1;
            check("abort_busy", L, 32'(busy), 32'd0);
            check("abort_ack", L, 32'(ack), 32'd0);
            check("abort_rdata", L, rdata, 32'h0);
            #1 clr = 1'b0;
            last_rd = 32'h0; last_known = 1'b1;
            repeat (3) @(posedge clk);
        endtask

        initial begin
            int          kind;
            logic [8:0]  a;
            logic [31:0] d;
            clr = 1'b1; rd = 1'b0; wr = 1'b0; addr = 9'd0; wdata = 32'd0;
            last_rd = 32'h0; last_known = 1'b1;
            repeat (3) @(posedge clk); #1;
            check("rst_rdata", L, rdata, 32'h0);
            check("rst_ack", L, 32'(ack), 32'd0);
            check("rst_busy", L, 32'(busy), 32'd0);
            check("rst_err", L, 32'(err), 32'd0);
            @(negedge clk); clr = 1'b0;
            repeat (2) @(posedge clk);

            do_req(1'b0, 1'b1, 9'd74, 32'd9);
            do_req(1'b1, 1'b0, 9'd74, 32'd0);
            do_req(1'b1, 1'b1, 9'd74, 32'hDEAD_BEEF);
            do_req(1'b1, 1'b0, 9'd74, 32'd0);
            do_req(1'b0, 1'b1, 9'd5, 32'h1111_1111);
            abort_write(9'd5, 32'hA5A5_A5A5);
            do_req(1'b1, 1'b0, 9'd5, 32'd0);
            do_req(1'b0, 1'b1, 9'd10, 32'h0000_0A0A);
            do_req(1'b0, 1'b1, 9'd11, 32'h0000_0B0B);
            do_req(1'b1, 1'b0, 9'd10, 32'd0);
            held_read(9'd74);
            do_req(1'b0, 1'b1, 9'd511, 32'hFFFF_0001);
            do_req(1'b1, 1'b0, 9'd511, 32'd0);

            repeat (40) begin
                kind = int'($urandom_range(0, 9));
                a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 31));
                d = $urandom;
                if (kind == 0)     do_req(1'b1, 1'b1, a, d);
                else if (kind < 5) do_req(1'b1, 1'b0, a, d);
                else               do_req(1'b0, 1'b1, a, d);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end

            repeat (L + 4) @(posedge clk);
            check("pending_acks", L, 32'(q.size()), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (done[0] && done[1] && done[2]) break;
        end
        if (!(done[0] && done[1] && done[2])) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: drivers done %0d%0d%0d, required 111", done[0], done[1], done[2]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
